motor_ramp_ctrl: RTL and testbench
==================================

# motor_ramp_ctrl

Command-side speed/direction sequencer that sits directly upstream of the motor driver and produces its `dir` and `speed` inputs. It accepts target commands over a valid/ready handshake and slews `speed` toward the target in fixed steps on a prescaled tick. A direction reversal is always performed as ramp-to-zero, dead time, direction flip, then ramp-up. An emergency-stop input forces immediate zero speed.

## Interface
- `STEP`, 16'd100: speed increment/decrement applied per ramp tick.
- `TICK_DIV`, 5000: clocks per ramp tick, ≥2.
- `DEAD_TICKS`, 10: ticks held at zero speed before a direction flip, ≥1.
- `MAX_SPEED`, 16'd50000: clamp applied to captured targets.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd_dir`  in  1  target direction.
- `cmd_speed`  in  16  target speed, unsigned.
- `estop`  in  1  emergency stop, level-sensitive.
- `dir`  out  1  direction to motor driver, registered.
- `speed`  out  16  speed to motor driver, registered.
- `busy`  out  1  state ≠ IDLE.
- `at_target`  out  1  `speed == target && dir == target_dir`.

## Operation
- Reset: `dir`=0, `speed`=0, target=0, target_dir=0, state IDLE, prescaler=0, dead counter=0, `cmd_ready`=1, `busy`=0, `at_target`=1.
- Prescaler: free-running 0..TICK_DIV-1. `tick` is a one-cycle pulse when count==TICK_DIV-1. It is not reset by commands or estop.
- Capture: on `cmd_valid && cmd_ready`, target = min(`cmd_speed`, MAX_SPEED) and target_dir = `cmd_dir`.
- States:
  - IDLE: speed==target and dir==target_dir. A capture with the same dir goes to RAMP if the clamped target ≠ speed. A capture with the opposite dir goes to BRAKE if speed≠0, or to DEAD if speed==0.
  - RAMP: on each tick, speed moves toward target by STEP. If |target−speed| ≤ STEP, speed = target, then go to IDLE. A capture is allowed (retarget); same-dir retargets stay in RAMP, opposite-dir retargets go to BRAKE.
  - BRAKE: on each tick, speed decrements by STEP, saturating at 0. When speed reaches 0, go to DEAD with the counter cleared.
  - DEAD: speed=0. The counter increments on each tick. At count DEAD_TICKS, `dir` = target_dir, counter is cleared, and the next state is RAMP (target>0) or IDLE.
- `cmd_ready` = 1 in IDLE and RAMP; 0 in BRAKE and DEAD, and 0 whenever `estop`=1.
- Step arithmetic uses 17-bit intermediates, so there is no wrap: increments clamp to target and decrements clamp to max(target, 0).
- estop has highest priority. While high: speed is forced to 0 on the next edge, target=0, state is DEAD, and the dead counter is held at 0. After release, DEAD counts DEAD_TICKS ticks, then the block goes to IDLE. target_dir is set to the current `dir`, so no flip occurs.
- `rst` overrides everything, including estop, on the same edge.

## Timing
- Capture takes effect at the accepting edge. The state changes on the same edge, and the first speed change occurs on the next `tick`.
- Ramp 0→S: ceil(S/STEP) ticks.
- Reversal from speed S to S2: ceil(S/STEP) BRAKE ticks, then DEAD_TICKS ticks, then `dir` flips on the DEAD_TICKS-th tick edge while speed is still 0, then ceil(S2/STEP) ticks.
- `dir` never changes while `speed`≠0. This invariant must be asserted.
- `busy` and `at_target` are derived combinationally from registered state, so they are valid in the same cycle as `speed` and `dir`.
- A capture coincident with a tick: the step is computed toward the new target.

## Structure
- Shared package `motor_pkg`: state enum (IDLE, RAMP, BRAKE, DEAD) and the speed-width constant (16).
- Sub-module `tick_prescaler` (parameter DIV; ports `clk`, `rst`, `tick`). It is reused by other timing blocks.

## Test plan
Bench parameters: TICK_DIV=4, STEP=100, DEAD_TICKS=2, MAX_SPEED=1000.
- Reset with estop=0: `speed`=0, `dir`=0, `cmd_ready`=1, `busy`=0, `at_target`=1.
- Command dir=0, speed=350: `speed` steps 100, 200, 300, 350 on successive ticks. `busy` drops and `at_target` rises with the 350 update.
- From 350 at dir 0, command dir=1, speed=200: `cmd_ready`=0. Speed goes 250, 150, 50, 0, then 2 dead ticks, then `dir`=1, then 100, 200.
- Command speed=5000: target clamped to 1000, and the ramp ends at 1000 after 10 ticks.
- During a ramp at 600 toward 1000, retarget to 300 with the same dir: speed goes 500, 400, 300, then IDLE.
- Assert estop at speed 700: `speed`=0 on the next edge and `cmd_ready`=0. After release, 2 ticks elapse, then IDLE with `dir` unchanged and `cmd_ready`=1.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and step arithmetic for the motor command sequencer.
package motor_pkg;

  localparam int SPEED_W = 16;

  typedef logic [SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    BRAKE,
    DEAD
  } state_e;

  // One slew step toward tgt. The gap is widened by a bit, so the step never wraps.
  function automatic speed_t step_toward(input speed_t cur, input speed_t tgt, input speed_t step);
    logic [SPEED_W:0] gap;
    if (tgt >= cur) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      return (gap <= {1'b0, step}) ? tgt : cur + step;
    end
    gap = {1'b0, cur} - {1'b0, tgt};
    return (gap <= {1'b0, step}) ? tgt : cur - step;
  endfunction

  function automatic speed_t step_down(input speed_t cur, input speed_t step);
    return ({1'b0, cur} <= {1'b0, step}) ? '0 : cur - step;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_prescaler #(
  parameter int DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == W'(DIV - 1));

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)       cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Speed/direction sequencer feeding the motor driver: ramps, reversals via dead time, estop.
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter speed_t STEP       = 16'd100,
  parameter int     TICK_DIV   = 5000,
  parameter int     DEAD_TICKS = 10,
  parameter speed_t MAX_SPEED  = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [SPEED_W-1:0] cmd_speed,
  input  logic               estop,
  output logic               dir,
  output logic [SPEED_W-1:0] speed,
  output logic               busy,
  output logic               at_target
);

  localparam int                 CNT_W     = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [CNT_W-1:0]   DEAD_LAST = CNT_W'(DEAD_TICKS - 1);

  state_e           state_q, state_d;
  speed_t           speed_q, speed_d, target_q, target_d;
  logic             dir_q, dir_d, tdir_q, tdir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   tick, accept, eff_dir;
  speed_t cap_speed, eff_target, ramp_speed, brake_speed;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cmd_ready = (state_q == IDLE || state_q == RAMP) && !estop;
  assign accept    = cmd_valid && cmd_ready;
  assign cap_speed = (cmd_speed > MAX_SPEED) ? MAX_SPEED : cmd_speed;

  // A capture on a tick edge steers that edge's step toward the new target.
  assign eff_target  = accept ? cap_speed : target_q;
  assign eff_dir     = accept ? cmd_dir : tdir_q;
  assign ramp_speed  = step_toward(speed_q, eff_target, STEP);
  assign brake_speed = step_down(speed_q, STEP);

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    dir_d    = dir_q;
    target_d = target_q;
    tdir_d   = tdir_q;
    cnt_d    = cnt_q;
    if (estop) begin
      speed_d  = '0;
      target_d = '0;
      tdir_d   = dir_q;
      cnt_d    = '0;
      state_d  = DEAD;
    end else begin
      if (accept) begin
        target_d = cap_speed;
        tdir_d   = cmd_dir;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (cmd_dir == dir_q)    state_d = (cap_speed != speed_q) ? RAMP : IDLE;
            else if (speed_q != '0)  state_d = BRAKE;
            else                     state_d = DEAD;
          end
        end
        RAMP: begin
          if (eff_dir != dir_q) begin
            state_d = BRAKE;
            if (tick) begin
              speed_d = brake_speed;
              if (brake_speed == '0) state_d = DEAD;
            end
          end else if (tick) begin
            speed_d = ramp_speed;
            if (ramp_speed == eff_target) state_d = IDLE;
          end
        end
        BRAKE: begin
          if (tick) begin
            speed_d = brake_speed;
            if (brake_speed == '0) state_d = DEAD;
          end
        end
        DEAD: begin
          speed_d = '0;
          if (tick) begin
            if (cnt_q == DEAD_LAST) begin
              dir_d   = tdir_q;
              cnt_d   = '0;
              state_d = (target_q != '0) ? RAMP : IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: only control registers exist here, so all of them take the reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      speed_q  <= '0;
      dir_q    <= 1'b0;
      target_q <= '0;
      tdir_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      dir_q    <= dir_d;
      target_q <= target_d;
      tdir_q   <= tdir_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dir       = dir_q;
  assign speed     = speed_q;
  assign busy      = (state_q != IDLE);
  assign at_target = (speed_q == target_q) && (dir_q == tdir_q);

  dir_stable_while_moving: assert property (@(posedge clk) disable iff (rst)
    (dir_q != $past(dir_q)) |-> (speed_q == '0 && $past(speed_q) == '0));

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed vector table plus randomized run against a reference model.
module tb_motor_ramp_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int STEP_I     = 100;
  localparam int DEAD_TICKS = 2;
  localparam int MAX_I      = 1000;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_ready, cmd_dir, estop, dir, busy, at_target;
  logic [15:0] cmd_speed, speed;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .STEP       (16'(STEP_I)),
    .TICK_DIV   (TICK_DIV),
    .DEAD_TICKS (DEAD_TICKS),
    .MAX_SPEED  (16'(MAX_I))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_speed (cmd_speed),
    .estop     (estop),
    .dir       (dir),
    .speed     (speed),
    .busy      (busy),
    .at_target (at_target)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: settled / slewing / stopping / waiting out dead time.
  typedef enum int {M_HOLD, M_SLEW, M_STOPPING, M_WAIT} mode_e;
  mode_e m_mode;
  int    m_speed, m_target, m_wait, edge_cnt, prev_speed;
  bit    m_dir, m_tdir, last_tick, prev_dir;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit tick;
    int cap;
    if (rst) begin
      m_mode = M_HOLD; m_speed = 0; m_target = 0; m_wait = 0;
      m_dir = 0; m_tdir = 0; edge_cnt = 0; last_tick = 0;
      return;
    end
    tick      = (edge_cnt % TICK_DIV) == TICK_DIV - 1;
    last_tick = tick;
    edge_cnt++;
    if (estop) begin
      m_speed = 0; m_target = 0; m_tdir = m_dir; m_mode = M_WAIT; m_wait = 0;
      return;
    end
    if (cmd_valid && (m_mode == M_HOLD || m_mode == M_SLEW)) begin
      cap      = (int'(cmd_speed) > MAX_I) ? MAX_I : int'(cmd_speed);
      m_target = cap;
      m_tdir   = cmd_dir;
      if (m_mode == M_HOLD) begin
        if (cmd_dir == m_dir)  m_mode = (cap != m_speed) ? M_SLEW : M_HOLD;
        else if (m_speed != 0) m_mode = M_STOPPING;
        else                   m_mode = M_WAIT;
        return;
      end
    end
    if (m_mode == M_SLEW && m_tdir != m_dir) m_mode = M_STOPPING;
    if (!tick) return;
    case (m_mode)
      M_SLEW: begin
        if (m_target - m_speed <= STEP_I && m_speed - m_target <= STEP_I) begin
          m_speed = m_target;
          m_mode  = M_HOLD;
        end else begin
          m_speed += (m_target > m_speed) ? STEP_I : -STEP_I;
        end
      end
      M_STOPPING: begin
        m_speed = (m_speed > STEP_I) ? m_speed - STEP_I : 0;
        if (m_speed == 0) begin m_mode = M_WAIT; m_wait = 0; end
      end
      M_WAIT: begin
        m_wait++;
        if (m_wait == DEAD_TICKS) begin
          m_dir  = m_tdir;
          m_wait = 0;
          m_mode = (m_target > 0) ? M_SLEW : M_HOLD;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    check("model speed", int'(speed), m_speed);
    check("model dir", int'(dir), int'(m_dir));
    check("model cmd_ready", int'(cmd_ready), int'((m_mode == M_HOLD || m_mode == M_SLEW) && !estop));
    check("model busy", int'(busy), int'(m_mode != M_HOLD));
    check("model at_target", int'(at_target), int'(m_speed == m_target && m_dir == m_tdir));
    if (!rst && dir != prev_dir) check("dir flip at zero speed", prev_speed + int'(speed), 0);
    prev_dir   = dir;
    prev_speed = int'(speed);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * TICK_DIV && !seen; i++) begin
      tick_clk();
      seen = last_tick;
    end
    check("ramp tick within budget", int'(seen), 1);
  endtask

  typedef struct {
    bit valid; bit cdir; int cspd; bit est; int n;
    int e_speed; bit e_dir; bit e_ready; bit e_busy; bit e_at;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit valid, bit cdir, int cspd, bit est, int n,
                              int e_speed, bit e_dir, bit e_ready, bit e_busy, bit e_at);
    vec_t v;
    v.valid = valid; v.cdir = cdir; v.cspd = cspd; v.est = est; v.n = n;
    v.e_speed = e_speed; v.e_dir = e_dir; v.e_ready = e_ready; v.e_busy = e_busy; v.e_at = e_at;
    return v;
  endfunction

  // Drive one command/estop cycle, then wait n ramp ticks and compare the outputs.
  task automatic apply_vec(input int idx, input vec_t v);
    cmd_valid = v.valid;
    cmd_dir   = v.cdir;
    cmd_speed = 16'(v.cspd);
    estop     = v.est;
    tick_clk();
    cmd_valid = 1'b0;
    repeat (v.n) wait_tick();
    check($sformatf("vec%0d speed", idx), int'(speed), v.e_speed);
    check($sformatf("vec%0d dir", idx), int'(dir), int'(v.e_dir));
    check($sformatf("vec%0d cmd_ready", idx), int'(cmd_ready), int'(v.e_ready));
    check($sformatf("vec%0d busy", idx), int'(busy), int'(v.e_busy));
    check($sformatf("vec%0d at_target", idx), int'(at_target), int'(v.e_at));
  endtask

  initial begin
    int est_left = 0;

    //              vld dir spd  est n   speed dir rdy busy at
    vecs.push_back(mk(1, 0, 350,  0, 1,  100, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  200, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  300, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  350, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 200,  0, 0,  350, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 900,  0, 0,  350, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  250, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  150, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,   50, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,    0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,    0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,    0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  100, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  200, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1000, 0, 5,  700, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    1, 0,    0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,    1, 2,    0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,    0, 1,    0, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,    0, 1,    0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 5000, 0, 9,  900, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1, 1000, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0,    0, 10,   0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1000, 0, 6,  600, 1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 300,  0, 1,  500, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  400, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 1,  300, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 300,  0, 0,  300, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0,    0, 3,    0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0,    0, 0,    0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,    0, 2,    0, 0, 1, 0, 1));

    rst = 1'b1; estop = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_speed = '0;
    prev_dir = 1'b0; prev_speed = 0;
    repeat (3) tick_clk();
    check("reset beats estop busy", int'(busy), 0);
    check("reset beats estop speed", int'(speed), 0);

    estop = 1'b0;
    tick_clk();
    check("reset speed", int'(speed), 0);
    check("reset dir", int'(dir), 0);
    check("reset cmd_ready", int'(cmd_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset at_target", int'(at_target), 1);
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Sparse commands first so ramps and reversals complete, then dense retargeting.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cmd_valid = ($urandom_range(0, 99) < ((cyc < 2000) ? 3 : 25));
      cmd_dir   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       cmd_speed = 16'(100 * $urandom_range(0, 12));
        1:       cmd_speed = 16'($urandom_range(0, 1300));
        2:       cmd_speed = 16'hFFFF;
        default: cmd_speed = '0;
      endcase
      if (est_left > 0) begin
        est_left--;
        estop = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        est_left = $urandom_range(1, 12);
        estop    = 1'b1;
      end else begin
        estop = 1'b0;
      end
      tick_clk();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
